// File: rtl/pan_pkg.sv
// rtl/pan_pkg.sv - shared types and constants for the stereo pan mixer
package pan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL_L,
    MUL_R,
    DONE
  } pan_state_t;

  localparam int          FRAC_BITS = 15;
  localparam logic [14:0] GAIN_MAX  = 15'h7FFF;

endpackage

// File: rtl/pan_mult.sv
// rtl/pan_mult.sv - combinational signed sample x unsigned Q1.15 gain, floor-scaled
//   sample : signed audio sample
//   gain   : unsigned fractional gain, 0 .. ~1.0
//   result : (sample * gain) >>> FRAC_BITS, truncated to DATA_W bits
module pan_mult #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic [DATA_W-1:0]    sample,
  input  logic [FRAC_BITS-1:0] gain,
  output logic [DATA_W-1:0]    result
);
  import pan_pkg::*;

  localparam int PW = DATA_W + FRAC_BITS + 1;

  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;

  // Gain is forced non-negative by a zero top bit so the product is signed x positive.
  assign sample_ext = PW'($signed(sample));
  assign gain_ext   = PW'({1'b0, gain});
  assign product    = sample_ext * gain_ext;

  // Gain < 1.0 keeps the scaled value inside DATA_W bits, so truncation never wraps.
  assign result = DATA_W'(product >>> FRAC_BITS);

endmodule

// File: rtl/stereo_pan_mixer.sv
// rtl/stereo_pan_mixer.sv - mono to stereo constant-sum panner with one shared multiplier
//   CLOCK_50     : clock
//   RESET        : synchronous active-high reset
//   SAMPLE_VALID : input strobe for SAMPLE_IN / AUTO_PAN
//   SAMPLE_IN    : signed mono sample
//   AUTO_PAN     : pan position, 0 = full right, 0x7FFF = full left, larger clamps
//   LEFT_OUT     : registered left sample
//   RIGHT_OUT    : registered right sample
//   OUT_VALID    : one-cycle strobe when LEFT_OUT / RIGHT_OUT update
//   BUSY         : computation in flight
//   OVERRUN      : sticky, a strobe arrived while busy and was dropped
module stereo_pan_mixer #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] SAMPLE_IN,
  input  logic [DATA_W-1:0] AUTO_PAN,
  output logic [DATA_W-1:0] LEFT_OUT,
  output logic [DATA_W-1:0] RIGHT_OUT,
  output logic              OUT_VALID,
  output logic              BUSY,
  output logic              OVERRUN
);
  import pan_pkg::*;

  pan_state_t state_q;
  pan_state_t state_d;

  logic [DATA_W-1:0]    sample_q;
  logic [DATA_W-1:0]    left_q;
  logic [DATA_W-1:0]    right_q;
  logic [DATA_W-1:0]    mul_out;
  logic [FRAC_BITS-1:0] gain_q;
  logic [FRAC_BITS-1:0] gain_in;
  logic [FRAC_BITS-1:0] mul_gain;
  logic                 accept;

  assign accept = SAMPLE_VALID && (state_q == IDLE);
  assign BUSY   = (state_q != IDLE);

  // Any pan bit at or above the fraction width means the value exceeds full-left.
  assign gain_in = (|AUTO_PAN[DATA_W-1:FRAC_BITS]) ? GAIN_MAX : AUTO_PAN[FRAC_BITS-1:0];

  // Right gain is the complement of the left gain; the multiplier is time-shared.
  assign mul_gain = (state_q == MUL_R) ? (GAIN_MAX - gain_q) : gain_q;

  pan_mult #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mult (
    .sample (sample_q),
    .gain   (mul_gain),
    .result (mul_out)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (SAMPLE_VALID) state_d = MUL_L;
      MUL_L:   state_d = MUL_R;
      MUL_R:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sample_q  <= '0;
      gain_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      LEFT_OUT  <= '0;
      RIGHT_OUT <= '0;
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      OUT_VALID <= (state_q == DONE);
      if (SAMPLE_VALID && BUSY) begin
        OVERRUN <= 1'b1;
      end
      if (accept) begin
        sample_q <= SAMPLE_IN;
        gain_q   <= gain_in;
      end
      if (state_q == MUL_L) begin
        left_q <= mul_out;
      end
      if (state_q == MUL_R) begin
        right_q <= mul_out;
      end
      if (state_q == DONE) begin
        LEFT_OUT  <= left_q;
        RIGHT_OUT <= right_q;
      end
    end
  end

endmodule

// File: tb/tb_stereo_pan_mixer.sv
// tb/tb_stereo_pan_mixer.sv - directed self-checking bench for stereo_pan_mixer
module tb_stereo_pan_mixer;

  logic        CLOCK_50;
  logic        RESET;
  logic        SAMPLE_VALID;
  logic [15:0] SAMPLE_IN;
  logic [15:0] AUTO_PAN;
  logic [15:0] LEFT_OUT;
  logic [15:0] RIGHT_OUT;
  logic        OUT_VALID;
  logic        BUSY;
  logic        OVERRUN;

  int checks   = 0;
  int failures = 0;

  stereo_pan_mixer dut (
    .CLOCK_50     (CLOCK_50),
    .RESET        (RESET),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_IN    (SAMPLE_IN),
    .AUTO_PAN     (AUTO_PAN),
    .LEFT_OUT     (LEFT_OUT),
    .RIGHT_OUT    (RIGHT_OUT),
    .OUT_VALID    (OUT_VALID),
    .BUSY         (BUSY),
    .OVERRUN      (OVERRUN)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    SAMPLE_VALID = 1'b1;
    SAMPLE_IN = 16'h4000;
    AUTO_PAN = 16'h4000;
    step();
    step();
    checks++;
    if (LEFT_OUT !== 16'h0000 || RIGHT_OUT !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs: got L=%h R=%h expected 0000 0000", LEFT_OUT, RIGHT_OUT);
    end
    checks++;
    if ({OUT_VALID, BUSY, OVERRUN} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got ov/busy/ovr=%b expected 000", {OUT_VALID, BUSY, OVERRUN});
    end
    RESET = 1'b0;
    SAMPLE_VALID = 1'b0;
    step();
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins_over_strobe: got BUSY=%b expected 0", BUSY);
    end
  endtask

  task automatic run_sample(input string name, input logic [15:0] s, input logic [15:0] p,
                            input logic [15:0] el, input logic [15:0] er);
    int n;
    SAMPLE_IN = s;
    AUTO_PAN = p;
    SAMPLE_VALID = 1'b1;
    step();
    SAMPLE_VALID = 1'b0;
    SAMPLE_IN = 16'($urandom);
    AUTO_PAN = 16'($urandom);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL %s busy: got %b expected 1", name, BUSY);
    end
    n = 1;
    while (OUT_VALID !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n - 1 !== 3) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles expected 3", name, n - 1);
    end
    checks++;
    if (LEFT_OUT !== el) begin
      failures++;
      $display("FAIL %s left: got %h expected %h", name, LEFT_OUT, el);
    end
    checks++;
    if (RIGHT_OUT !== er) begin
      failures++;
      $display("FAIL %s right: got %h expected %h", name, RIGHT_OUT, er);
    end
    step();
    checks++;
    if (OUT_VALID !== 1'b0 || LEFT_OUT !== el || RIGHT_OUT !== er) begin
      failures++;
      $display("FAIL %s hold: got ov=%b L=%h R=%h expected ov=0 L=%h R=%h",
               name, OUT_VALID, LEFT_OUT, RIGHT_OUT, el, er);
    end
  endtask

  task automatic test_pan_values();
    run_sample("centre",   16'h4000, 16'h4000, 16'h2000, 16'h1FFF);
    run_sample("left_ext", 16'h8000, 16'h7FFF, 16'h8001, 16'h0000);
    run_sample("right_ext",16'h7FFF, 16'h0000, 16'h0000, 16'h7FFE);
    run_sample("clamp",    16'h4000, 16'hFFFF, 16'h3FFF, 16'h0000);
    run_sample("neg_floor",16'hC000, 16'h2000, 16'hF000, 16'hD000);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 8; c++) begin
      SAMPLE_VALID = (c == 0 || c == 4);
      SAMPLE_IN = (c == 4) ? 16'h7FFF : 16'h4000;
      AUTO_PAN = (c == 4) ? 16'h0000 : 16'h4000;
      checks++;
      if (OUT_VALID !== (c == 4 || c == 8)) begin
        failures++;
        $display("FAIL b2b_valid c=%0d: got %b expected %b", c, OUT_VALID, (c == 4 || c == 8));
      end
      checks++;
      if (BUSY !== (c % 4 != 0)) begin
        failures++;
        $display("FAIL b2b_busy c=%0d: got %b expected %b", c, BUSY, (c % 4 != 0));
      end
      if (c >= 4 && c <= 7) begin
        checks++;
        if (LEFT_OUT !== 16'h2000 || RIGHT_OUT !== 16'h1FFF) begin
          failures++;
          $display("FAIL b2b_first c=%0d: got L=%h R=%h expected 2000 1FFF", c, LEFT_OUT, RIGHT_OUT);
        end
      end
      if (c == 8) begin
        checks++;
        if (LEFT_OUT !== 16'h0000 || RIGHT_OUT !== 16'h7FFE) begin
          failures++;
          $display("FAIL b2b_second: got L=%h R=%h expected 0000 7FFE", LEFT_OUT, RIGHT_OUT);
        end
        checks++;
        if (OVERRUN !== 1'b0) begin
          failures++;
          $display("FAIL b2b_no_overrun: got %b expected 0", OVERRUN);
        end
      end
      if (c < 8) step();
    end
    SAMPLE_VALID = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    for (int c = 0; c <= 9; c++) begin
      SAMPLE_VALID = (c == 0 || c == 2 || c == 4);
      case (c)
        0:       begin SAMPLE_IN = 16'h4000; AUTO_PAN = 16'h4000; end
        2:       begin SAMPLE_IN = 16'h7FFF; AUTO_PAN = 16'h7FFF; end
        4:       begin SAMPLE_IN = 16'h8000; AUTO_PAN = 16'h7FFF; end
        default: begin SAMPLE_IN = 16'h1234; AUTO_PAN = 16'h0100; end
      endcase
      checks++;
      if (OUT_VALID !== (c == 4 || c == 8)) begin
        failures++;
        $display("FAIL ovr_valid c=%0d: got %b expected %b", c, OUT_VALID, (c == 4 || c == 8));
      end
      checks++;
      if (OVERRUN !== (c >= 3)) begin
        failures++;
        $display("FAIL ovr_flag c=%0d: got %b expected %b", c, OVERRUN, (c >= 3));
      end
      if (c == 4) begin
        checks++;
        if (LEFT_OUT !== 16'h2000 || RIGHT_OUT !== 16'h1FFF) begin
          failures++;
          $display("FAIL ovr_first: got L=%h R=%h expected 2000 1FFF", LEFT_OUT, RIGHT_OUT);
        end
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (LEFT_OUT !== 16'h8001 || RIGHT_OUT !== 16'h0000) begin
          failures++;
          $display("FAIL ovr_second c=%0d: got L=%h R=%h expected 8001 0000", c, LEFT_OUT, RIGHT_OUT);
        end
      end
      if (c < 9) step();
    end
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 9; c++) begin
      RESET = (c == 2);
      SAMPLE_VALID = (c == 0 || c == 3);
      SAMPLE_IN = (c == 3) ? 16'hC000 : 16'h4000;
      AUTO_PAN = (c == 3) ? 16'h2000 : 16'h4000;
      checks++;
      if (OUT_VALID !== (c == 7)) begin
        failures++;
        $display("FAIL rst_mid_valid c=%0d: got %b expected %b", c, OUT_VALID, (c == 7));
      end
      if (c == 3) begin
        checks++;
        if (LEFT_OUT !== 16'h0000 || RIGHT_OUT !== 16'h0000 || BUSY !== 1'b0 || OVERRUN !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid_clear: got L=%h R=%h busy=%b ovr=%b expected 0000 0000 0 0",
                   LEFT_OUT, RIGHT_OUT, BUSY, OVERRUN);
        end
      end
      if (c == 4) begin
        checks++;
        if (BUSY !== 1'b1) begin
          failures++;
          $display("FAIL rst_mid_accept: got BUSY=%b expected 1", BUSY);
        end
      end
      if (c == 7) begin
        checks++;
        if (LEFT_OUT !== 16'hF000 || RIGHT_OUT !== 16'hD000) begin
          failures++;
          $display("FAIL rst_mid_result: got L=%h R=%h expected F000 D000", LEFT_OUT, RIGHT_OUT);
        end
      end
      if (c < 9) step();
    end
    RESET = 1'b0;
    SAMPLE_VALID = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    SAMPLE_VALID = 1'b0;
    SAMPLE_IN = '0;
    AUTO_PAN = '0;
    test_reset();
    test_pan_values();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stereo_pan_mixer.md
STEREO_PAN_MIXER -- requirements
Module: stereo_pan_mixer

Interface
REQ-001 Parameter DATA_W, default 16: audio sample width; all requirements and values below assume 16.
REQ-002 Parameter FRAC_BITS, default 15: gain fraction bits; gain range is 0 (0.0) to 0x7FFF (~1.0).
REQ-003 CLOCK_50  in  1  sole clock; all state updates on the rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 SAMPLE_VALID  in  1  one-cycle strobe; the sample and pan inputs are valid this cycle.
REQ-006 SAMPLE_IN  in  16  signed mono audio sample.
REQ-007 AUTO_PAN  in  16  unsigned pan position from the LFO autopanner; 0x0000 is full right, 0x7FFF is full left.
REQ-008 LEFT_OUT  out  16  signed registered left channel sample.
REQ-009 RIGHT_OUT  out  16  signed registered right channel sample.
REQ-010 OUT_VALID  out  1  one-cycle strobe; LEFT_OUT and RIGHT_OUT are updated and valid.
REQ-011 BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-012 OVERRUN  out  1  sticky; set when an input strobe is dropped.

Function
REQ-013 FSM states: IDLE, MUL_L, MUL_R, DONE. Transitions: IDLE->MUL_L on SAMPLE_VALID; MUL_L->MUL_R; MUL_R->DONE; DONE->IDLE. All transitions other than IDLE are unconditional.
REQ-014 On acceptance in IDLE: latch SAMPLE_IN; latch gain G = min(AUTO_PAN, 0x7FFF), so any input above 0x7FFF clamps to 0x7FFF.
REQ-015 Left gain = G; right gain = 0x7FFF - G.
REQ-016 Single shared multiplier: MUL_L computes the left product and MUL_R computes the right product, each into an internal register.
REQ-017 Product: signed 16-bit sample times {0, gain[14:0]} gives a 32-bit signed result; output = product >>> 15, keeping bits [30:15]. Arithmetic shift gives floor rounding; no saturation is needed.
REQ-018 In DONE, LEFT_OUT and RIGHT_OUT load together and OUT_VALID=1 for exactly one cycle. Latency from the strobe edge to OUT_VALID is 3 cycles.
REQ-019 LEFT_OUT and RIGHT_OUT hold their value between OUT_VALID pulses.
REQ-020 SAMPLE_VALID while BUSY=1 is dropped: it has no effect on the in-flight computation and sets OVERRUN.
REQ-021 Maximum accepted rate is one sample per 4 cycles. A strobe arriving exactly 4 cycles after the previous one is accepted.
REQ-022 Changing AUTO_PAN or SAMPLE_IN mid-computation has no effect on the current result.

Reset
REQ-023 RESET=1 forces the following: state IDLE; LEFT_OUT=0; RIGHT_OUT=0; OUT_VALID=0; BUSY=0; OVERRUN=0; latched operands cleared.
REQ-024 RESET asserted mid-operation aborts the computation; no OUT_VALID is produced for the aborted sample.
REQ-025 If RESET and SAMPLE_VALID are high in the same cycle, reset wins and the sample is not accepted.
REQ-026 SAMPLE_VALID is accepted on the first cycle after RESET deasserts.

Structure
REQ-027 Package pan_pkg holds:
- the state enum pan_state_t {IDLE, MUL_L, MUL_R, DONE};
- constant GAIN_MAX = 15'h7FFF;
- constant FRAC_BITS = 15.
REQ-028 One sub-module, pan_mult, holds the combinational signed-sample by unsigned-Q1.15 multiply with the >>>15 shift. It is instantiated once and its operands are muxed by the FSM.
REQ-029 No other sub-modules; target size is 120-250 lines of RTL.

Verification
REQ-030 Centre pan:
- Stimulus: SAMPLE_IN=0x4000, AUTO_PAN=0x4000.
- Response: OUT_VALID 3 cycles later; LEFT_OUT=0x2000, RIGHT_OUT=0x1FFF.
REQ-031 Extremes, left:
- Stimulus: SAMPLE_IN=0x8000, AUTO_PAN=0x7FFF.
- Response: LEFT_OUT=0x8001, RIGHT_OUT=0x0000.
REQ-032 Extremes, right:
- Stimulus: SAMPLE_IN=0x7FFF, AUTO_PAN=0x0000.
- Response: LEFT_OUT=0x0000, RIGHT_OUT=0x7FFE.
REQ-033 Clamp:
- Stimulus: AUTO_PAN=0xFFFF, SAMPLE_IN=0x4000.
- Response: LEFT_OUT=0x3FFF, RIGHT_OUT=0x0000.
REQ-034 Overrun:
- Stimulus: strobes at cycles 0, 2 and 4.
- Response: results for cycles 0 and 4 only; the cycle-2 strobe is dropped; OVERRUN=1 from cycle 3 and stays high until RESET.
REQ-035 Reset mid-operation:
- Stimulus: RESET at cycle 2 after a strobe.
- Response: no OUT_VALID; outputs 0; a strobe the cycle after RESET deasserts produces a correct result 3 cycles later.
